shared_mem_responder: RTL and testbench
=======================================

SHARED_MEM_RESPONDER -- requirements
Module: shared_mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning memory word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning request address width.
REQ-003 The block SHALL have parameter DEPTH, default 64, meaning number of memory words, indexed by address[5:0].
REQ-004 The block SHALL have port clk, input, 1 bit: single positive-edge clock for all logic.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on the clk rising edge.
REQ-006 The block SHALL have port req, input, 4 bits: per-requester access request, held high until the transaction completes.
REQ-007 The block SHALL have port ack, output, 4 bits: one-hot grant, at most one bit high.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any grant or transaction is open.
REQ-009 The block SHALL have port valid, input, 1 bit: the granted requester's address, rw and data_in are valid.
REQ-010 The block SHALL have port rw, input, 1 bit: 1 = write, 0 = read.
REQ-011 The block SHALL have port address, input, ADDR_W bits: word address.
REQ-012 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-013 The block SHALL have port data_out, output, DATA_W bits: read data.
REQ-014 The block SHALL have port data_out_valid, output, 1 bit: one-cycle pulse qualifying data_out.
REQ-015 The block SHALL have port grant_id, output, 2 bits: index of the current or last granted requester.
REQ-016 The block SHALL have port err, output, 1 bit: one-cycle pulse flagging an out-of-range access.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT and DONE.
REQ-018 In IDLE with any req bit high, the block SHALL select the first requester at or after (last_grant+1) mod 4 with req high, set that ack bit, set busy and grant_id, and enter GRANT on the same edge.
REQ-019 In GRANT, ack SHALL stay asserted until valid is sampled high, or until the granted req drops.
REQ-020 In GRANT with valid=1, rw=1 and address[7:6]=0, the block SHALL write data_in to mem[address[5:0]] on that edge, clear ack and enter DONE.
REQ-021 In GRANT with valid=1, rw=0 and address[7:6]=0, the block SHALL register mem[address[5:0]] onto data_out, pulse data_out_valid for exactly the following cycle, clear ack and enter DONE.
REQ-022 For address[7:6]!=0, a write SHALL be discarded, a read SHALL return data_out=0 with a data_out_valid pulse, err SHALL pulse alongside, and the FSM SHALL enter DONE.
REQ-023 If the granted req drops in GRANT before valid, the block SHALL clear ack and busy and return to IDLE with no memory access.
REQ-024 In DONE, busy SHALL stay high until the granted req is sampled low, then the FSM SHALL return to IDLE.
REQ-025 last_grant SHALL update to the granted index on each grant, so that four continuous requesters are served in order 0,1,2,3,0.
REQ-026 New req edges arriving during GRANT or DONE SHALL be held pending and arbitrated only from IDLE.
REQ-027 valid sampled outside GRANT SHALL be ignored.
REQ-028 Latency SHALL be: req to ack 1 cycle; valid to data_out_valid 1 cycle; minimum 4 cycles per transaction.

Reset
REQ-029 While reset=0 at the clock edge, the block SHALL clear ack=0, busy=0, data_out=0, data_out_valid=0, err=0 and grant_id=0, set the FSM to IDLE, set last_grant=3, and clear all DEPTH memory words to 0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction, with no memory write completing on that edge.

Verification
REQ-031 The bench SHALL cover: after reset, req=4'b0001, write addr 8'h05 data 8'hA5, then req=4'b0001 read addr 8'h05 -> ack[0] one cycle after req, then data_out=8'hA5 with data_out_valid pulsing one cycle after valid.
REQ-032 The bench SHALL cover: req=4'b1111 held with each grantee completing a transaction -> grant order 0,1,2,3,0 and ack always one-hot.
REQ-033 The bench SHALL cover: write 8'h3C to addr 8'h45 -> err pulse, no memory word changed; read of addr 8'h45 -> data_out=0 with err.
REQ-034 The bench SHALL cover: req[2] raised then dropped in GRANT without valid -> ack=0 and busy=0 next cycle, memory unchanged.
REQ-035 The bench SHALL cover: reset=0 asserted during GRANT with valid=1 and rw=1 -> no write, all outputs 0; a subsequent read of that address returns 8'h00.
REQ-036 The bench SHALL cover: valid=1 pulsed while in IDLE -> no access and no data_out_valid.

Source files
------------

// File: rtl/shared_mem_responder_if.sv
// shared_mem_responder_if: request/grant and memory access bus between requesters and the responder
interface shared_mem_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [3:0]        req;
  logic [3:0]        ack;
  logic              busy;
  logic              valid;
  logic              rw;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic [1:0]        grant_id;
  logic              err;
  modport master (
    output req, valid, rw, address, data_in,
    input  ack, busy, data_out, data_out_valid, grant_id, err
  );
  modport slave (
    input  req, valid, rw, address, data_in,
    output ack, busy, data_out, data_out_valid, grant_id, err
  );
endinterface

// File: rtl/shared_mem_responder.sv
// shared_mem_responder: round-robin arbitrated single-port memory shared by four requesters
module shared_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64
) (
  input logic                   clk,
  input logic                   reset,
  shared_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  state_t            r_state;
  logic [3:0]        r_ack;
  logic              r_busy;
  logic              r_dov;
  logic              r_err;
  logic [DATA_W-1:0] r_data_out;
  logic [1:0]        r_grant_id;
  logic [1:0]        r_last_grant;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [1:0]        w_sel;
  logic              w_oor;
  logic              w_held;
  // descending scan so the closest requester after last_grant wins
  always_comb begin
    w_sel = r_last_grant;
    for (int i = 4; i >= 1; i--)
      if (bus.req[2'(r_last_grant + 2'(i))]) w_sel = 2'(r_last_grant + 2'(i));
  end
  assign w_oor  = |(bus.address >> AW);
  assign w_held = bus.req[r_grant_id];
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ack        <= '0;
      r_busy       <= 1'b0;
      r_dov        <= 1'b0;
      r_err        <= 1'b0;
      r_data_out   <= '0;
      r_grant_id   <= '0;
      r_last_grant <= 2'd3;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_dov <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE:
          if (|bus.req) begin
            r_ack        <= 4'b1 << w_sel;
            r_busy       <= 1'b1;
            r_grant_id   <= w_sel;
            r_last_grant <= w_sel;
            r_state      <= GRANT;
          end
        GRANT:
          if (!w_held) begin
            r_ack   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (bus.valid) begin
            if (bus.rw && !w_oor) r_mem[bus.address[AW-1:0]] <= bus.data_in;
            if (!bus.rw) begin
              r_data_out <= w_oor ? '0 : r_mem[bus.address[AW-1:0]];
              r_dov      <= 1'b1;
            end
            r_err   <= w_oor;
            r_ack   <= '0;
            r_state <= DONE;
          end
        DONE:
          if (!w_held) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ack            = r_ack;
  assign bus.busy           = r_busy;
  assign bus.data_out       = r_data_out;
  assign bus.data_out_valid = r_dov;
  assign bus.grant_id       = r_grant_id;
  assign bus.err            = r_err;
endmodule

// File: tb/tb_shared_mem_responder.sv
// tb_shared_mem_responder: directed scenario tests for shared_mem_responder
module tb_shared_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  shared_mem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus ();
  shared_mem_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    bus.req = '0; bus.valid = 1'b0; bus.rw = 1'b0; bus.address = '0; bus.data_in = '0;
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic grant(input int i);
    @(negedge clk);
    bus.req[i] = 1'b1;
    tick();
  endtask
  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.valid = 1'b1; bus.rw = w; bus.address = a; bus.data_in = d;
    tick();
  endtask
  task automatic finish_req(input int i);
    @(negedge clk);
    bus.valid = 1'b0;
    bus.req[i] = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    do_reset();
    n_cmp++; if (bus.ack !== 4'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
    n_cmp++; if (bus.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dov: got %b want 0", bus.data_out_valid); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_cmp++; if (bus.grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", bus.grant_id); end
  endtask
  task automatic test_write_read;
    grant(0);
    n_cmp++; if (bus.ack !== 4'b0001) begin n_bad++; $display("FAIL wr_ack: got %b want 0001", bus.ack); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b want 1", bus.busy); end
    issue(1'b1, 8'h05, 8'hA5);
    n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL wr_ack_clear: got %b want 0000", bus.ack); end
    n_cmp++; if (bus.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL wr_dov: got %b want 0", bus.data_out_valid); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL wr_done_busy: got %b want 1", bus.busy); end
    finish_req(0);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL wr_release_busy: got %b want 0", bus.busy); end
    grant(0);
    n_cmp++; if (bus.ack !== 4'b0001) begin n_bad++; $display("FAIL rd_ack: got %b want 0001", bus.ack); end
    issue(1'b0, 8'h05, 8'h00);
    n_cmp++; if (bus.data_out_valid !== 1'b1) begin n_bad++; $display("FAIL rd_dov: got %b want 1", bus.data_out_valid); end
    n_cmp++; if (bus.data_out !== 8'hA5) begin n_bad++; $display("FAIL rd_data: got %h want a5", bus.data_out); end
    finish_req(0);
    n_cmp++; if (bus.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL rd_dov_pulse: got %b want 0", bus.data_out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rd_release_busy: got %b want 0", bus.busy); end
  endtask
  task automatic test_out_of_range;
    grant(1);
    n_cmp++; if (bus.grant_id !== 2'd1) begin n_bad++; $display("FAIL oor_grant_id: got %0d want 1", bus.grant_id); end
    issue(1'b1, 8'h45, 8'h3C);
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL oor_wr_err: got %b want 1", bus.err); end
    n_cmp++; if (bus.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL oor_wr_dov: got %b want 0", bus.data_out_valid); end
    finish_req(1);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL oor_err_pulse: got %b want 0", bus.err); end
    grant(1);
    issue(1'b0, 8'h05, 8'h00);
    n_cmp++; if (bus.data_out !== 8'hA5) begin n_bad++; $display("FAIL oor_alias_intact: got %h want a5", bus.data_out); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL oor_inrange_err: got %b want 0", bus.err); end
    finish_req(1);
    grant(1);
    issue(1'b0, 8'h45, 8'h00);
    n_cmp++; if (bus.data_out !== 8'h00) begin n_bad++; $display("FAIL oor_rd_data: got %h want 00", bus.data_out); end
    n_cmp++; if (bus.data_out_valid !== 1'b1) begin n_bad++; $display("FAIL oor_rd_dov: got %b want 1", bus.data_out_valid); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL oor_rd_err: got %b want 1", bus.err); end
    finish_req(1);
  endtask
  task automatic test_req_drop;
    grant(1);
    issue(1'b1, 8'h0A, 8'h77);
    finish_req(1);
    grant(2);
    n_cmp++; if (bus.ack !== 4'b0100) begin n_bad++; $display("FAIL drop_ack: got %b want 0100", bus.ack); end
    n_cmp++; if (bus.grant_id !== 2'd2) begin n_bad++; $display("FAIL drop_grant_id: got %0d want 2", bus.grant_id); end
    @(negedge clk);
    bus.rw = 1'b1; bus.address = 8'h0A; bus.data_in = 8'hFF; bus.req[2] = 1'b0;
    tick();
    n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL drop_ack_clear: got %b want 0000", bus.ack); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", bus.busy); end
    grant(2);
    issue(1'b0, 8'h0A, 8'h00);
    n_cmp++; if (bus.data_out !== 8'h77) begin n_bad++; $display("FAIL drop_mem: got %h want 77", bus.data_out); end
    finish_req(2);
  endtask
  task automatic test_valid_idle;
    grant(0);
    issue(1'b1, 8'h11, 8'h33);
    finish_req(0);
    @(negedge clk);
    bus.valid = 1'b1; bus.rw = 1'b1; bus.address = 8'h11; bus.data_in = 8'hEE;
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_valid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL idle_valid_ack: got %b want 0000", bus.ack); end
    @(negedge clk);
    bus.rw = 1'b0;
    tick();
    n_cmp++; if (bus.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid_dov: got %b want 0", bus.data_out_valid); end
    @(negedge clk);
    bus.valid = 1'b0;
    grant(0);
    issue(1'b0, 8'h11, 8'h00);
    n_cmp++; if (bus.data_out !== 8'h33) begin n_bad++; $display("FAIL idle_valid_mem: got %h want 33", bus.data_out); end
    finish_req(0);
  endtask
  task automatic test_reset_mid;
    grant(3);
    n_cmp++; if (bus.ack !== 4'b1000) begin n_bad++; $display("FAIL rstmid_ack: got %b want 1000", bus.ack); end
    @(negedge clk);
    bus.valid = 1'b1; bus.rw = 1'b1; bus.address = 8'h10; bus.data_in = 8'h5A; reset = 1'b0;
    tick();
    n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL rstmid_ack_clear: got %b want 0000", bus.ack); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.grant_id !== 2'd0) begin n_bad++; $display("FAIL rstmid_grant_id: got %0d want 0", bus.grant_id); end
    n_cmp++; if (bus.data_out !== 8'h00) begin n_bad++; $display("FAIL rstmid_data_out: got %h want 00", bus.data_out); end
    n_cmp++; if (bus.err !== 1'b0 || bus.data_out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_pulses: got err=%b dov=%b want 0 0", bus.err, bus.data_out_valid); end
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    tick();
    grant(3);
    issue(1'b0, 8'h10, 8'h00);
    n_cmp++; if (bus.data_out !== 8'h00 || bus.data_out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_read: got %h dov=%b want 00 dov=1", bus.data_out, bus.data_out_valid); end
    finish_req(3);
  endtask
  task automatic test_round_robin;
    logic [3:0] exp_ack;
    do_reset();
    @(negedge clk);
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_ack = 4'b0001 << (k % 4);
      n_cmp++; if (bus.ack !== exp_ack) begin n_bad++; $display("FAIL rr_ack_%0d: got %b want %b", k, bus.ack, exp_ack); end
      n_cmp++; if (bus.grant_id !== 2'(k % 4)) begin n_bad++; $display("FAIL rr_grant_id_%0d: got %0d want %0d", k, bus.grant_id, k % 4); end
      issue(1'b0, 8'(k), 8'h00);
      n_cmp++; if (!$onehot0(bus.ack) || bus.data_out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_done_%0d: got ack=%b dov=%b want onehot0 dov=1", k, bus.ack, bus.data_out_valid); end
      finish_req(k % 4);
      @(negedge clk);
      bus.req[k % 4] = 1'b1;
      tick();
    end
    @(negedge clk);
    clear_inputs();
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    clear_inputs();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_req_drop();
    test_valid_idle();
    test_reset_mid();
    test_round_robin();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
